// File: rtl/viterbi_decoder_param.sv
`default_nettype none
// ============================================================================
//  Module   : viterbi_decoder_param
//  Purpose  : Hard-decision Viterbi decoder for rate-1/2 convolutional codes
//             with parametrised constraint length and generator polynomials.
//             One add-compare-select per accepted symbol, circular survivor
//             memory, per-symbol traceback and an end-of-block flush.
//  Ports    : clk, rst           - clock, asynchronous active-high reset
//             in_sym[1:0]        - received symbol {c1,c0}
//             in_valid/in_ready  - input handshake
//             in_last            - final symbol of a block
//             out_bit            - decoded bit
//             out_valid/out_ready- output handshake
//             out_last           - final decoded bit of a block
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module viterbi_decoder_param #(
    parameter int             K        = 3,
    parameter logic [K-1:0]   G0       = 3'o7,
    parameter logic [K-1:0]   G1       = 3'o5,
    parameter int             TB_DEPTH = 15,
    parameter int             PM_W     = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] in_sym,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_bit,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready
);

    localparam int SW    = K - 1;
    localparam int NS    = 1 << SW;
    localparam int PTR_W = (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1;
    localparam int CNT_W = $clog2(TB_DEPTH + 1);

    localparam logic [PTR_W-1:0] C_COL_LAST  = PTR_W'(TB_DEPTH - 1);
    localparam logic [PTR_W-1:0] C_STEP_LAST = PTR_W'(TB_DEPTH - 2);
    localparam logic [CNT_W-1:0] C_DEPTH     = CNT_W'(TB_DEPTH);
    localparam logic [PM_W-1:0]  C_PM_INIT   = PM_W'(1 << (PM_W - 2));

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TRACE  = 3'd1,
        ST_EMIT   = 3'd2,
        ST_FTRACE = 3'd3,
        ST_FEMIT  = 3'd4
    } state_t;

    state_t r_state, w_state_nx;

    logic [PM_W-1:0]   r_pm [NS];
    logic [NS-1:0]     r_dec [TB_DEPTH];
    logic [CNT_W-1:0]  r_cnt;
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_col;
    logic [PTR_W-1:0]  r_step;
    logic              r_first;
    logic [SW-1:0]     r_tb_state;
    logic [PTR_W-1:0]  r_idx;
    logic [PTR_W-1:0]  r_eidx;
    logic [CNT_W-1:0]  r_pend;
    logic [TB_DEPTH-1:0] r_buf;
    logic              r_out_bit;

    logic              w_acc;
    logic [PM_W-1:0]   w_pm_acs [NS];
    logic [NS-1:0]     w_dec_col;
    logic [NS-1:0]     w_msb;
    logic              w_norm;
    logic [PM_W-1:0]   w_clr;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [SW-1:0]     w_best;
    logic [PM_W-1:0]   w_best_pm;
    logic [SW-1:0]     w_cur;
    logic [SW-1:0]     w_prev;
    logic [PTR_W-1:0]  w_col_dec;
    logic [PTR_W-1:0]  w_eidx_nx;
    logic              w_last_bit;

    // in_ready depends only on state, so the acceptance term is built from
    // the state directly to keep the combinational graph acyclic.
    assign w_acc = in_valid & (r_state == ST_IDLE);

    // ------------------------------------------------------------------
    // Add-compare-select, one butterfly half per destination state.
    // Predecessors of ns are {ns[K-3:0], b}; the newest input is ns MSB.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_acs
            localparam logic [SW-1:0] C_NS = SW'(gi);
            localparam logic [SW-1:0] C_P0 = {C_NS[SW-2:0], 1'b0};
            localparam logic [SW-1:0] C_P1 = {C_NS[SW-2:0], 1'b1};
            localparam logic [K-1:0]  C_R0 = {C_NS[SW-1], C_P0};
            localparam logic [K-1:0]  C_R1 = {C_NS[SW-1], C_P1};
            localparam logic [1:0]    C_E0 = {^(C_R0 & G0), ^(C_R0 & G1)};
            localparam logic [1:0]    C_E1 = {^(C_R1 & G0), ^(C_R1 & G1)};

            logic [1:0]      w_x0, w_x1;
            logic [1:0]      w_bm0, w_bm1;
            logic [PM_W-1:0] w_s0, w_s1;

            assign w_x0  = in_sym ^ C_E0;
            assign w_x1  = in_sym ^ C_E1;
            assign w_bm0 = {1'b0, w_x0[1]} + {1'b0, w_x0[0]};
            assign w_bm1 = {1'b0, w_x1[1]} + {1'b0, w_x1[0]};
            assign w_s0  = r_pm[C_P0] + PM_W'(w_bm0);
            assign w_s1  = r_pm[C_P1] + PM_W'(w_bm1);

            // strict compare: a tie keeps the b=0 predecessor
            assign w_dec_col[gi] = (w_s1 < w_s0);
            assign w_pm_acs[gi]  = w_dec_col[gi] ? w_s1 : w_s0;
            assign w_msb[gi]     = w_pm_acs[gi][PM_W-1];
        end
    endgenerate

    // Subtracting 2^(PM_W-1) from every metric preserves all comparisons.
    assign w_norm = &w_msb;
    assign w_clr  = {w_norm, {(PM_W-1){1'b0}}};

    assign w_cnt_next = (r_cnt == C_DEPTH) ? r_cnt : r_cnt + 1'b1;

    // Lowest metric, lowest index on ties.
    always_comb begin
        w_best    = '0;
        w_best_pm = r_pm[0];
        for (int i = 1; i < NS; i++) begin
            if (r_pm[i] < w_best_pm) begin
                w_best_pm = r_pm[i];
                w_best    = SW'(i);
            end
        end
    end

    // Traceback step: the survivor bit is the oldest state bit shifted back in.
    assign w_cur      = r_first ? w_best : r_tb_state;
    assign w_prev     = {w_cur[SW-2:0], r_dec[r_col][w_cur]};
    assign w_col_dec  = (r_col == '0) ? C_COL_LAST : r_col - 1'b1;
    assign w_eidx_nx  = r_eidx + 1'b1;
    assign w_last_bit = (CNT_W'(r_eidx) == (r_pend - 1'b1));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (w_acc) begin
                    if (in_last) begin
                        w_state_nx = ST_FTRACE;
                    end else if (w_cnt_next == C_DEPTH) begin
                        w_state_nx = ST_TRACE;
                    end
                end
            end
            ST_TRACE: begin
                if (r_step == C_STEP_LAST) begin
                    w_state_nx = ST_EMIT;
                end
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_FTRACE: begin
                if (r_idx == '0) begin
                    w_state_nx = ST_FEMIT;
                end
            end
            ST_FEMIT: begin
                out_valid = 1'b1;
                out_last  = w_last_bit;
                if (out_ready && w_last_bit) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    assign out_bit = r_out_bit;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                r_pm[i] <= (i == 0) ? '0 : C_PM_INIT;
            end
            r_cnt      <= '0;
            r_wptr     <= '0;
            r_col      <= '0;
            r_step     <= '0;
            r_first    <= 1'b0;
            r_tb_state <= '0;
            r_idx      <= '0;
            r_eidx     <= '0;
            r_pend     <= '0;
            r_buf      <= '0;
            r_out_bit  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_acc) begin
                        for (int i = 0; i < NS; i++) begin
                            r_pm[i] <= w_pm_acs[i] & ~w_clr;
                        end
                        r_wptr  <= (r_wptr == C_COL_LAST) ? '0 : r_wptr + 1'b1;
                        r_cnt   <= w_cnt_next;
                        // traceback starts at the column just written
                        r_col   <= r_wptr;
                        r_step  <= '0;
                        r_first <= 1'b1;
                        r_idx   <= PTR_W'(w_cnt_next - 1'b1);
                        r_pend  <= w_cnt_next;
                    end
                end
                ST_TRACE: begin
                    r_first    <= 1'b0;
                    r_tb_state <= w_prev;
                    r_col      <= w_col_dec;
                    r_step     <= r_step + 1'b1;
                    if (r_step == C_STEP_LAST) begin
                        r_out_bit <= w_prev[SW-1];
                    end
                end
                ST_FTRACE: begin
                    // newest bit lands at the highest index so emission
                    // can walk the buffer upward, oldest first
                    r_first      <= 1'b0;
                    r_buf[r_idx] <= w_cur[SW-1];
                    if (r_idx == '0) begin
                        r_out_bit <= w_cur[SW-1];
                        r_eidx    <= '0;
                    end else begin
                        r_tb_state <= w_prev;
                        r_col      <= w_col_dec;
                        r_idx      <= r_idx - 1'b1;
                    end
                end
                ST_FEMIT: begin
                    if (out_ready) begin
                        if (w_last_bit) begin
                            for (int i = 0; i < NS; i++) begin
                                r_pm[i] <= (i == 0) ? '0 : C_PM_INIT;
                            end
                            r_cnt <= '0;
                        end else begin
                            r_eidx    <= w_eidx_nx;
                            r_out_bit <= r_buf[w_eidx_nx];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Survivor memory: contents need no reset.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_dec[r_wptr] <= w_dec_col;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_viterbi_decoder_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_viterbi_decoder_param
//  Purpose  : Self-checking bench for viterbi_decoder_param. Two instances
//             (K=3 7/5 depth 15, K=5 23/35 depth 30) share the stimulus
//             signals; a selector routes handshakes to one of them.
//  Revision : 1.0 - initial bench
// ============================================================================
module tb_viterbi_decoder_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] in_sym = '0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic       sel = 1'b0;

    logic a_in_ready, a_out_bit, a_out_valid, a_out_last;
    logic b_in_ready, b_out_bit, b_out_valid, b_out_last;
    logic m_in_ready, m_out_bit, m_out_valid, m_out_last;

    assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign m_out_bit   = sel ? b_out_bit   : a_out_bit;
    assign m_out_valid = sel ? b_out_valid : a_out_valid;
    assign m_out_last  = sel ? b_out_last  : a_out_last;

    always #5 clk = ~clk;

    viterbi_decoder_param #(.K(3), .G0(3'o7), .G1(3'o5), .TB_DEPTH(15), .PM_W(6)) dut_a (
        .clk(clk), .rst(rst), .in_sym(in_sym), .in_valid(in_valid & ~sel),
        .in_last(in_last), .in_ready(a_in_ready), .out_bit(a_out_bit),
        .out_valid(a_out_valid), .out_last(a_out_last), .out_ready(out_ready)
    );

    viterbi_decoder_param #(.K(5), .G0(5'o23), .G1(5'o35), .TB_DEPTH(30), .PM_W(6)) dut_b (
        .clk(clk), .rst(rst), .in_sym(in_sym), .in_valid(in_valid & sel),
        .in_last(in_last), .in_ready(b_in_ready), .out_bit(b_out_bit),
        .out_valid(b_out_valid), .out_last(b_out_last), .out_ready(out_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    int syms     [0:599];
    int src_bits [0:599];
    int exp_bits [0:599];
    int hs_cyc   [0:599];
    int best_m   [0:599];
    bit dec_m    [0:599][0:15];
    int got_bits [$];
    int got_last [$];
    int got_cyc  [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int par(input int x);
        return $countones(x) & 1;
    endfunction

    task automatic encode(input int k, input int g0, input int g1, input int n);
        int s, u, r;
        s = 0;
        for (int i = 0; i < n; i++) begin
            u = src_bits[i];
            r = (u << (k - 1)) | s;
            syms[i] = (par(r & g0) << 1) | par(r & g1);
            s = (u << (k - 2)) | (s >> 1);
        end
    endtask

    // Reference decoder: unbounded metrics over the whole block, full
    // decision history, windowed traceback from the best state.
    task automatic model(input int k, input int g0, input int g1, input int tbd, input int n);
        longint pm [0:15];
        longint npm [0:15];
        longint c, bc;
        int nst, u, p, r, bm, db, s, pend, bi;
        nst = 1 << (k - 1);
        for (int i = 0; i < nst; i++) pm[i] = (i == 0) ? 0 : 16;
        for (int t = 0; t < n; t++) begin
            for (int ns = 0; ns < nst; ns++) begin
                u  = ns >> (k - 2);
                bc = 0;
                db = 0;
                for (int b = 0; b < 2; b++) begin
                    p  = ((ns << 1) & (nst - 1)) | b;
                    r  = (u << (k - 1)) | p;
                    bm = (((syms[t] >> 1) & 1) ^ par(r & g0)) + ((syms[t] & 1) ^ par(r & g1));
                    c  = pm[p] + bm;
                    if (b == 0 || c < bc) begin
                        bc = c;
                        db = b;
                    end
                end
                npm[ns] = bc;
                dec_m[t][ns] = db[0];
            end
            bi = 0;
            for (int i = 0; i < nst; i++) begin
                pm[i] = npm[i];
                if (npm[i] < npm[bi]) bi = i;
            end
            best_m[t] = bi;
        end
        for (int t = tbd - 1; t < n - 1; t++) begin
            s = best_m[t];
            for (int j = 0; j < tbd - 1; j++) s = ((s << 1) & (nst - 1)) | int'(dec_m[t - j][s]);
            exp_bits[t - tbd + 1] = (s >> (k - 2)) & 1;
        end
        pend = (n < tbd) ? n : tbd;
        s = best_m[n - 1];
        exp_bits[n - 1] = (s >> (k - 2)) & 1;
        for (int j = 1; j < pend; j++) begin
            s = ((s << 1) & (nst - 1)) | int'(dec_m[n - j][s]);
            exp_bits[n - 1 - j] = (s >> (k - 2)) & 1;
        end
    endtask

    // rm: 0 always ready, 1 random ready, 2 hold ready low 5 cycles per output
    // vm: 0 continuous valid, 1 random gaps (a raised valid is held until taken)
    task automatic run_block(input int s, input int n, input int rm, input int vm, input int tbd);
        int idx, cyc, budget, hold;
        bit acc, prev_ov, prev_rdy, prev_ob, prev_ol;
        sel = s[0];
        got_bits.delete();
        got_last.delete();
        got_cyc.delete();
        idx = 0; cyc = 0; hold = 0; acc = 0;
        prev_ov = 0; prev_rdy = 1; prev_ob = 0; prev_ol = 0;
        budget = n * (tbd + 12) * 4 + 200;
        while (got_bits.size() < n && cyc < budget) begin
            @(negedge clk);
            if (prev_ov && !prev_rdy) begin
                chk("hold_valid", m_out_valid, 1);
                chk("hold_bit", m_out_bit, prev_ob);
                chk("hold_last", m_out_last, prev_ol);
            end
            if (m_out_valid) chk("busy_in_ready", m_in_ready, 0);
            if (acc) in_valid = 1'b0;
            acc = 0;
            if (idx < n) begin
                if (!in_valid) in_valid = (vm == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                in_sym  = 2'(syms[idx]);
                in_last = (idx == n - 1);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            case (rm)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    out_ready = (hold >= 5);
                    if (m_out_valid) hold = out_ready ? 0 : hold + 1;
                end
            endcase
            if (in_valid && m_in_ready) begin
                hs_cyc[idx] = cyc;
                idx++;
                acc = 1;
            end
            if (m_out_valid && out_ready) begin
                got_bits.push_back(int'(m_out_bit));
                got_last.push_back(int'(m_out_last));
                got_cyc.push_back(cyc);
            end
            prev_ov = m_out_valid; prev_rdy = out_ready;
            prev_ob = m_out_bit;   prev_ol  = m_out_last;
            cyc++;
        end
        chk("out_count", got_bits.size(), n);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        chk("idle_in_ready", m_in_ready, 1);
        chk("idle_out_valid", m_out_valid, 0);
    endtask

    task automatic compare_out(input string tag, input int n);
        for (int i = 0; i < got_bits.size(); i++) begin
            chk({tag, "_bit"}, got_bits[i], exp_bits[i]);
            chk({tag, "_last"}, got_last[i], (i == n - 1) ? 1 : 0);
        end
    endtask

    task automatic rand_src(input int n);
        for (int i = 0; i < n; i++) src_bits[i] = $urandom_range(0, 1);
    endtask

    initial begin
        int nerr;
        int lens [4];
        lens = '{14, 15, 16, 31};

        // ---------------- reset values
        #1 rst = 1'b1;
        #2;
        sel = 1'b0; #1;
        chk("rst_a_in_ready", m_in_ready, 1);
        chk("rst_a_out_valid", m_out_valid, 0);
        chk("rst_a_out_bit", m_out_bit, 0);
        chk("rst_a_out_last", m_out_last, 0);
        sel = 1'b1; #1;
        chk("rst_b_in_ready", m_in_ready, 1);
        chk("rst_b_out_valid", m_out_valid, 0);
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // ---------------- short block 11,10,00,01 -> 1,0,1,1
        syms[0] = 3; syms[1] = 2; syms[2] = 0; syms[3] = 1;
        exp_bits[0] = 1; exp_bits[1] = 0; exp_bits[2] = 1; exp_bits[3] = 1;
        run_block(0, 4, 0, 0, 15);
        compare_out("short", 4);

        // ---------------- in_last on the very first symbol
        src_bits[0] = 1;
        encode(3, 'o7, 'o5, 1);
        exp_bits[0] = 1;
        run_block(0, 1, 0, 0, 15);
        compare_out("single", 1);

        // ---------------- error-free 40-bit stream, latency
        rand_src(40);
        encode(3, 'o7, 'o5, 40);
        model(3, 'o7, 'o5, 15, 40);
        run_block(0, 40, 0, 0, 15);
        compare_out("clean", 40);
        if (got_cyc.size() > 0) chk("latency", got_cyc[0] - hs_cyc[14], 15);
        nerr = 0;
        for (int i = 0; i < got_bits.size(); i++) if (got_bits[i] != src_bits[i]) nerr++;
        chk("clean_vs_src", nerr, 0);

        // ---------------- single errors in symbols 5 and 25
        syms[5]  = syms[5] ^ 1;
        syms[25] = syms[25] ^ 2;
        model(3, 'o7, 'o5, 15, 40);
        run_block(0, 40, 0, 0, 15);
        compare_out("corr", 40);
        nerr = 0;
        for (int i = 0; i < got_bits.size(); i++) if (got_bits[i] != src_bits[i]) nerr++;
        chk("corr_vs_src", nerr, 0);

        // ---------------- backpressure: 5-cycle stalls on every output
        rand_src(60);
        encode(3, 'o7, 'o5, 60);
        model(3, 'o7, 'o5, 15, 60);
        run_block(0, 60, 2, 1, 15);
        compare_out("bp", 60);

        // ---------------- lengths around the traceback depth
        foreach (lens[j]) begin
            rand_src(lens[j]);
            encode(3, 'o7, 'o5, lens[j]);
            model(3, 'o7, 'o5, 15, lens[j]);
            run_block(0, lens[j], 1, 1, 15);
            compare_out("len", lens[j]);
        end

        // ---------------- reset mid-run (decoder parked in EMIT)
        rand_src(40);
        encode(3, 'o7, 'o5, 40);
        sel = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_last  = 1'b0;
            in_sym   = 2'(syms[i % 15]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_valid", m_out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", m_in_ready, 1);
        chk("mid_rst_out_valid", m_out_valid, 0);
        chk("mid_rst_out_last", m_out_last, 0);
        chk("mid_rst_out_bit", m_out_bit, 0);
        @(negedge clk);
        rst = 1'b0;
        rand_src(40);
        encode(3, 'o7, 'o5, 40);
        model(3, 'o7, 'o5, 15, 40);
        run_block(0, 40, 1, 1, 15);
        compare_out("post_rst", 40);

        // ---------------- K=5, G 23/35, depth 30, 500 symbols, ~3% errors
        rand_src(500);
        encode(5, 'o23, 'o35, 500);
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) < 3) syms[i] = syms[i] ^ (1 << $urandom_range(0, 1));
        end
        model(5, 'o23, 'o35, 30, 500);
        run_block(1, 500, 1, 1, 30);
        compare_out("k5", 500);

        rand_src(7);
        encode(5, 'o23, 'o35, 7);
        model(5, 'o23, 'o35, 30, 7);
        run_block(1, 7, 0, 1, 30);
        compare_out("k5_short", 7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
